// File: rtl/flash_byte_streamer_if.sv
// rtl/flash_byte_streamer_if.sv - Avalon-MM read bus between the byte streamer and the flash controller
interface flash_byte_streamer_if;
  logic        read;
  logic [22:0] address;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output read, address, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  read, address, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/flash_byte_streamer.sv
// rtl/flash_byte_streamer.sv - fetches 32-bit flash words and streams them out byte by byte, forward or reverse
module flash_byte_streamer #(
  parameter logic [22:0] WORD_DELTA = 23'd1,
  parameter logic [22:0] START_WORD = 23'h000000,
  parameter logic [22:0] END_WORD   = 23'h07FFFF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         reverse,
  output logic                         byte_valid,
  input  logic                         byte_ready,
  output logic [7:0]                   byte_data,
  output logic                         wrapped,
  output logic                         busy,
  flash_byte_streamer_if.master        flash_mem
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, PRESENT} state_t;

  state_t      state, state_nxt;
  logic [22:0] word_q, word_nxt;
  logic [1:0]  byte_q, byte_nxt;
  logic [31:0] buf_q, buf_nxt;
  logic        stop_q, stop_nxt;
  logic        wrapped_nxt;

  logic [22:0] step_word;
  logic [1:0]  step_byte;
  logic        step_wrap;
  logic        step_new_word;
  logic        fwd_wrap;
  logic        rev_wrap;

  // Wrap is decided by distance to the window edge so the step never overflows.
  assign fwd_wrap = (END_WORD - word_q) < WORD_DELTA;
  assign rev_wrap = (word_q - START_WORD) < WORD_DELTA;

  always_comb begin
    step_word     = word_q;
    step_byte     = byte_q;
    step_wrap     = 1'b0;
    step_new_word = 1'b0;
    if (!reverse) begin
      step_byte = byte_q + 2'd1;
      if (byte_q == 2'd3) begin
        step_new_word = 1'b1;
        step_wrap     = fwd_wrap;
        step_word     = fwd_wrap ? START_WORD : word_q + WORD_DELTA;
      end
    end else begin
      step_byte = byte_q - 2'd1;
      if (byte_q == 2'd0) begin
        step_new_word = 1'b1;
        step_wrap     = rev_wrap;
        step_word     = rev_wrap ? END_WORD : word_q - WORD_DELTA;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      word_q  <= START_WORD;
      byte_q  <= 2'd0;
      buf_q   <= 32'd0;
      stop_q  <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      state   <= state_nxt;
      word_q  <= word_nxt;
      byte_q  <= byte_nxt;
      buf_q   <= buf_nxt;
      stop_q  <= stop_nxt;
      wrapped <= wrapped_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    word_nxt    = word_q;
    byte_nxt    = byte_q;
    buf_nxt     = buf_q;
    stop_nxt    = stop_q;
    wrapped_nxt = 1'b0;
    case (state)
      IDLE: begin
        stop_nxt = 1'b0;
        if (start) begin
          word_nxt  = reverse ? END_WORD : START_WORD;
          byte_nxt  = reverse ? 2'd3 : 2'd0;
          state_nxt = REQ;
        end
      end
      REQ: begin
        // A stop here is remembered so the outstanding read still completes.
        stop_nxt = stop_q | stop;
        if (!flash_mem.waitrequest) begin
          state_nxt = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        stop_nxt = stop_q | stop;
        if (flash_mem.readdatavalid) begin
          if (stop_q || stop) begin
            state_nxt = IDLE;
          end else begin
            buf_nxt   = flash_mem.readdata;
            state_nxt = PRESENT;
          end
        end
      end
      PRESENT: begin
        if (byte_ready) begin
          word_nxt    = step_word;
          byte_nxt    = step_byte;
          wrapped_nxt = step_wrap;
          if (stop) begin
            state_nxt = IDLE;
          end else if (step_new_word) begin
            state_nxt = REQ;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign flash_mem.read       = (state == REQ);
  assign flash_mem.address    = word_q;
  assign flash_mem.byteenable = 4'b1111;
  assign byte_valid           = (state == PRESENT);
  assign busy                 = (state != IDLE);
  assign byte_data            = buf_q[{byte_q, 3'b000} +: 8];

endmodule

// File: tb/tb_flash_byte_streamer.sv
// tb/tb_flash_byte_streamer.sv - scoreboard bench for flash_byte_streamer over three window configurations
module tb_flash_byte_streamer;
  localparam int NDUT = 3;
  localparam logic [22:0] ST [NDUT] = '{23'd0, 23'd2, 23'd0};
  localparam logic [22:0] EN [NDUT] = '{23'd7, 23'd3, 23'd5};

  logic clk = 1'b0;
  logic reset;
  logic [NDUT-1:0] start, stop, reverse, byte_ready;
  logic [NDUT-1:0] byte_valid, wrapped, busy;
  logic [7:0]      byte_data [NDUT];
  logic [NDUT-1:0] rd_v, rdv_v;
  logic [22:0]     addr_v [NDUT];
  logic [3:0]      be_v [NDUT];
  int              rdcnt_v [NDUT];
  logic [22:0]     last_v [NDUT];

  logic [31:0] mem [0:7];
  int wait_cfg = 0;
  int resp_lat = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] sb [$];

  flash_byte_streamer_if bus [NDUT] ();

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gen_u
    logic [3:0]  wcnt;
    int          lat;
    logic        pend;
    logic [22:0] paddr;
    int          rd_cnt = 0;
    logic [22:0] last_addr = '0;

    flash_byte_streamer #(
      .WORD_DELTA(23'd1),
      .START_WORD(ST[g]),
      .END_WORD(EN[g])
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .start(start[g]),
      .stop(stop[g]),
      .reverse(reverse[g]),
      .byte_valid(byte_valid[g]),
      .byte_ready(byte_ready[g]),
      .byte_data(byte_data[g]),
      .wrapped(wrapped[g]),
      .busy(busy[g]),
      .flash_mem(bus[g])
    );

    assign bus[g].waitrequest = bus[g].read && (int'(wcnt) < wait_cfg);
    assign rd_v[g]    = bus[g].read;
    assign rdv_v[g]   = bus[g].readdatavalid;
    assign addr_v[g]  = bus[g].address;
    assign be_v[g]    = bus[g].byteenable;
    assign rdcnt_v[g] = rd_cnt;
    assign last_v[g]  = last_addr;

    always @(posedge clk or posedge reset) begin
      if (reset) begin
        wcnt <= '0;
        pend <= 1'b0;
        lat <= 0;
        paddr <= '0;
        bus[g].readdatavalid <= 1'b0;
        bus[g].readdata <= '0;
      end else begin
        bus[g].readdatavalid <= 1'b0;
        if (bus[g].read) begin
          if (bus[g].waitrequest) begin
            wcnt <= wcnt + 4'd1;
          end else begin
            wcnt <= '0;
            pend <= 1'b1;
            lat <= resp_lat;
            paddr <= bus[g].address;
            rd_cnt <= rd_cnt + 1;
            last_addr <= bus[g].address;
          end
        end
        if (pend) begin
          if (lat == 0) begin
            pend <= 1'b0;
            bus[g].readdatavalid <= 1'b1;
            bus[g].readdata <= mem[paddr[2:0]];
          end else begin
            lat <= lat - 1;
          end
        end
      end
    end
  end

  task automatic idle_all();
    start = '0;
    stop = '0;
    reverse = '0;
    byte_ready = '0;
  endtask

  task automatic pulse_start(input int g, input logic rev);
    @(negedge clk);
    reverse[g] = rev;
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_valid(input int g, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (byte_valid[g]) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int g, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!busy[g]) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    idle_all();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      n_checks++; if (busy[g] !== 1'b0) begin n_fail++; $display("FAIL reset_busy dut%0d got %b exp 0", g, busy[g]); end
      n_checks++; if (byte_valid[g] !== 1'b0) begin n_fail++; $display("FAIL reset_valid dut%0d got %b exp 0", g, byte_valid[g]); end
      n_checks++; if (wrapped[g] !== 1'b0) begin n_fail++; $display("FAIL reset_wrapped dut%0d got %b exp 0", g, wrapped[g]); end
      n_checks++; if (rd_v[g] !== 1'b0) begin n_fail++; $display("FAIL reset_read dut%0d got %b exp 0", g, rd_v[g]); end
      n_checks++; if (addr_v[g] !== ST[g]) begin n_fail++; $display("FAIL reset_addr dut%0d got %h exp %h", g, addr_v[g], ST[g]); end
      n_checks++; if (be_v[g] !== 4'hF) begin n_fail++; $display("FAIL reset_be dut%0d got %h exp f", g, be_v[g]); end
      n_checks++; if (byte_data[g] !== 8'h00) begin n_fail++; $display("FAIL reset_data dut%0d got %h exp 00", g, byte_data[g]); end
    end
  endtask

  task automatic test_forward();
    int base, rc, badaddr;
    bit ok;
    logic [7:0] expb;
    mem[0] = 32'hDDCCBBAA;
    mem[1] = 32'h88776655;
    wait_cfg = 2;
    resp_lat = 1;
    base = rdcnt_v[0];
    rc = 0;
    badaddr = 0;
    sb.push_back(8'hAA); sb.push_back(8'hBB); sb.push_back(8'hCC); sb.push_back(8'hDD);
    byte_ready[0] = 1'b1;
    pulse_start(0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (byte_valid[0]) ok = 1'b1;
      else begin
        if (rd_v[0]) begin rc++; if (addr_v[0] !== 23'd0) badaddr++; end
        @(negedge clk);
      end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL fwd_first_valid timeout"); end
    n_checks++; if (rc != 3 || badaddr != 0) begin n_fail++; $display("FAIL fwd_req_hold cycles %0d bad_addr %0d exp 3 0", rc, badaddr); end
    for (int k = 0; k < 4; k++) begin
      expb = sb.pop_front();
      n_checks++; if (byte_valid[0] !== 1'b1 || byte_data[0] !== expb) begin n_fail++; $display("FAIL fwd_byte%0d got %b/%h exp 1/%h", k, byte_valid[0], byte_data[0], expb); end
      @(negedge clk);
    end
    n_checks++; if (byte_valid[0] !== 1'b0 || rd_v[0] !== 1'b1 || addr_v[0] !== 23'd1) begin n_fail++; $display("FAIL fwd_next_read got v%b r%b a%h exp v0 r1 a1", byte_valid[0], rd_v[0], addr_v[0]); end
    n_checks++; if (rdcnt_v[0] - base != 1) begin n_fail++; $display("FAIL fwd_one_read got %0d exp 1", rdcnt_v[0] - base); end
    stop[0] = 1'b1;
    wait_idle(0, ok);
    stop[0] = 1'b0;
    byte_ready[0] = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL fwd_stop_idle timeout"); end
  endtask

  task automatic test_reverse();
    bit ok;
    logic [7:0] expb;
    mem[5] = 32'h44332211;
    wait_cfg = 0;
    resp_lat = 0;
    sb.push_back(8'h44); sb.push_back(8'h33); sb.push_back(8'h22); sb.push_back(8'h11);
    byte_ready[2] = 1'b1;
    pulse_start(2, 1'b1);
    wait_valid(2, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rev_first_valid timeout"); end
    n_checks++; if (last_v[2] !== 23'd5) begin n_fail++; $display("FAIL rev_first_addr got %h exp 5", last_v[2]); end
    for (int k = 0; k < 4; k++) begin
      expb = sb.pop_front();
      n_checks++; if (byte_valid[2] !== 1'b1 || byte_data[2] !== expb) begin n_fail++; $display("FAIL rev_byte%0d got %b/%h exp 1/%h", k, byte_valid[2], byte_data[2], expb); end
      @(negedge clk);
    end
    n_checks++; if (rd_v[2] !== 1'b1 || addr_v[2] !== 23'd4) begin n_fail++; $display("FAIL rev_next_read got r%b a%h exp r1 a4", rd_v[2], addr_v[2]); end
    stop[2] = 1'b1;
    wait_idle(2, ok);
    stop[2] = 1'b0;
    byte_ready[2] = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rev_stop_idle timeout"); end
  endtask

  task automatic test_wrap();
    int seen, wrapcnt;
    bit ok;
    logic [7:0] expb;
    mem[2] = 32'hA3A2A1A0;
    mem[3] = 32'hB3B2B1B0;
    wait_cfg = 0;
    resp_lat = 0;
    for (int w = 2; w <= 3; w++)
      for (int b = 0; b < 4; b++) sb.push_back(mem[w][8*b +: 8]);
    seen = 0;
    wrapcnt = 0;
    byte_ready[1] = 1'b1;
    pulse_start(1, 1'b0);
    for (int i = 0; i < 200 && seen < 8; i++) begin
      if (wrapped[1]) wrapcnt++;
      if (byte_valid[1]) begin
        expb = sb.pop_front();
        seen++;
        n_checks++; if (byte_data[1] !== expb) begin n_fail++; $display("FAIL wrap_byte%0d got %h exp %h", seen, byte_data[1], expb); end
      end
      if (seen < 8) @(negedge clk);
    end
    n_checks++; if (seen != 8 || wrapcnt != 0) begin n_fail++; $display("FAIL wrap_stream seen %0d early_wraps %0d exp 8 0", seen, wrapcnt); end
    @(negedge clk);
    n_checks++; if (wrapped[1] !== 1'b1 || addr_v[1] !== 23'd2) begin n_fail++; $display("FAIL wrap_fwd got w%b a%h exp w1 a2", wrapped[1], addr_v[1]); end
    @(negedge clk);
    n_checks++; if (wrapped[1] !== 1'b0) begin n_fail++; $display("FAIL wrap_fwd_pulse got %b exp 0", wrapped[1]); end
    wait_valid(1, ok);
    n_checks++; if (!ok || byte_data[1] !== 8'hA0) begin n_fail++; $display("FAIL wrap_refetch got %b/%h exp 1/a0", ok, byte_data[1]); end
    reverse[1] = 1'b1;
    @(negedge clk);
    n_checks++; if (wrapped[1] !== 1'b1 || addr_v[1] !== 23'd3 || byte_valid[1] !== 1'b0) begin n_fail++; $display("FAIL wrap_rev got w%b a%h v%b exp w1 a3 v0", wrapped[1], addr_v[1], byte_valid[1]); end
    stop[1] = 1'b1;
    wait_idle(1, ok);
    stop[1] = 1'b0;
    reverse[1] = 1'b0;
    byte_ready[1] = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_stop_idle timeout"); end
  endtask

  task automatic test_backpressure();
    int bad;
    bit ok;
    logic [7:0] expb;
    mem[0] = 32'hDDCCBBAA;
    wait_cfg = 0;
    resp_lat = 0;
    bad = 0;
    sb.push_back(8'hAA); sb.push_back(8'hBB);
    byte_ready[0] = 1'b0;
    pulse_start(0, 1'b0);
    wait_valid(0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_first_valid timeout"); end
    expb = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      if (byte_valid[0] !== 1'b1 || byte_data[0] !== expb) bad++;
      @(negedge clk);
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_stable unstable_cycles %0d exp 0", bad); end
    byte_ready[0] = 1'b1;
    @(negedge clk);
    expb = sb.pop_front();
    n_checks++; if (byte_valid[0] !== 1'b1 || byte_data[0] !== expb) begin n_fail++; $display("FAIL bp_advance got %b/%h exp 1/%h", byte_valid[0], byte_data[0], expb); end
    byte_ready[0] = 1'b0;
    stop[0] = 1'b1;
    @(negedge clk);
    n_checks++; if (busy[0] !== 1'b1 || byte_valid[0] !== 1'b1 || byte_data[0] !== 8'hBB) begin n_fail++; $display("FAIL bp_stop_held got b%b v%b d%h exp b1 v1 dbb", busy[0], byte_valid[0], byte_data[0]); end
    byte_ready[0] = 1'b1;
    @(negedge clk);
    n_checks++; if (busy[0] !== 1'b0 || byte_valid[0] !== 1'b0) begin n_fail++; $display("FAIL bp_stop_at_hs got b%b v%b exp b0 v0", busy[0], byte_valid[0]); end
    stop[0] = 1'b0;
    byte_ready[0] = 1'b0;
  endtask

  task automatic test_direction_flip();
    int seen, base, reads_at_b1, cyc, cyc_b2, cyc_b1;
    bit ok;
    logic [7:0] expb;
    for (int w = 0; w < 8; w++)
      mem[w] = {8'(16*w+3), 8'(16*w+2), 8'(16*w+1), 8'(16*w)};
    for (int w = 0; w < 7; w++)
      for (int b = 0; b < 4; b++) sb.push_back(8'(16*w+b));
    sb.push_back(8'h70); sb.push_back(8'h71); sb.push_back(8'h72);
    sb.push_back(8'h71); sb.push_back(8'h70); sb.push_back(8'h63);
    wait_cfg = 1;
    resp_lat = 0;
    base = rdcnt_v[0];
    seen = 0;
    reads_at_b1 = -1;
    cyc_b2 = 0;
    cyc_b1 = 0;
    byte_ready[0] = 1'b1;
    pulse_start(0, 1'b0);
    for (cyc = 0; cyc < 400 && seen < 34; cyc++) begin
      if (byte_valid[0]) begin
        expb = sb.pop_front();
        seen++;
        n_checks++; if (byte_data[0] !== expb) begin n_fail++; $display("FAIL flip_byte%0d got %h exp %h", seen, byte_data[0], expb); end
        if (seen == 31) begin reverse[0] = 1'b1; cyc_b2 = cyc; end
        if (seen == 32) begin reads_at_b1 = rdcnt_v[0] - base; cyc_b1 = cyc; end
        if (seen == 34) stop[0] = 1'b1;
      end
      @(negedge clk);
    end
    n_checks++; if (seen != 34) begin n_fail++; $display("FAIL flip_count got %0d exp 34", seen); end
    n_checks++; if (reads_at_b1 != 8 || cyc_b1 - cyc_b2 != 1) begin n_fail++; $display("FAIL flip_no_refetch reads %0d gap %0d exp 8 1", reads_at_b1, cyc_b1 - cyc_b2); end
    n_checks++; if (last_v[0] !== 23'd6) begin n_fail++; $display("FAIL flip_prev_word got %h exp 6", last_v[0]); end
    wait_idle(0, ok);
    stop[0] = 1'b0;
    reverse[0] = 1'b0;
    byte_ready[0] = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL flip_stop_idle timeout"); end
  endtask

  task automatic test_stop_reset();
    int base, vhigh, rdvs;
    bit ok;
    wait_cfg = 0;
    resp_lat = 3;
    base = rdcnt_v[2];
    vhigh = 0;
    rdvs = 0;
    byte_ready[2] = 1'b1;
    pulse_start(2, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (rdcnt_v[2] != base) ok = 1'b1;
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stop_accept timeout"); end
    stop[2] = 1'b1;
    @(negedge clk);
    stop[2] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (byte_valid[2]) vhigh++;
      if (rdv_v[2]) rdvs++;
      @(negedge clk);
    end
    n_checks++; if (vhigh != 0 || rdvs != 1) begin n_fail++; $display("FAIL stop_wait_data valid_cycles %0d rdv %0d exp 0 1", vhigh, rdvs); end
    n_checks++; if (busy[2] !== 1'b0) begin n_fail++; $display("FAIL stop_busy got %b exp 0", busy[2]); end
    wait_cfg = 5;
    resp_lat = 0;
    pulse_start(2, 1'b0);
    n_checks++; if (rd_v[2] !== 1'b1) begin n_fail++; $display("FAIL rst_read_pre got %b exp 1", rd_v[2]); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (rd_v[2] !== 1'b0 || busy[2] !== 1'b0 || byte_valid[2] !== 1'b0 || wrapped[2] !== 1'b0) begin n_fail++; $display("FAIL rst_async_ctrl got r%b b%b v%b w%b exp 0000", rd_v[2], busy[2], byte_valid[2], wrapped[2]); end
    n_checks++; if (addr_v[2] !== 23'd0 || byte_data[2] !== 8'h00) begin n_fail++; $display("FAIL rst_async_data got a%h d%h exp 0 00", addr_v[2], byte_data[2]); end
    @(negedge clk);
    reset = 1'b0;
    byte_ready[2] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_all();
    test_reset();
    test_forward();
    test_reverse();
    test_wrap();
    test_backpressure();
    test_direction_flip();
    test_stop_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
